// File: rtl/fetch_arb_pkg.sv
// ---------------------------------------------------------------------------
// fetch_arb_pkg: shared types for the fetch-port arbiter.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  localparam logic WAY0 = 1'b0;
  localparam logic WAY1 = 1'b1;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_WAY0 = 2'b01;
  localparam logic [1:0] GNT_WAY1 = 2'b10;

  function automatic logic [1:0] way_onehot(input logic way);
    return (way == WAY1) ? GNT_WAY1 : GNT_WAY0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_port_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2: two-way round-robin pick with a registered favour pointer.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter2
  import fetch_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       pick_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    valid_o = |req_i;
    case (req_i)
      2'b01:   pick_o = WAY0;
      2'b10:   pick_o = WAY1;
      2'b11:   pick_o = ptr_q;
      default: pick_o = WAY0;
    endcase
  end

  // After serving a way, favour the other one.
  assign ptr_d = advance_i ? ~last_i : ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= WAY0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_port_arbiter.sv
// ---------------------------------------------------------------------------
// fetch_port_arbiter: shares one fetch port between two ways, round-robin.
// Define FETCH_ARB_PERF_CNT_EN to add saturating perf counters.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_port_arbiter
  import fetch_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jumpFlag_i,
  input  logic              way0_request_i,
  input  logic [ADDR_W-1:0] way0_instAddr_i,
  output logic [DATA_W-1:0] way0_inst_o,
  output logic              way0_dataOk_o,
  input  logic              way1_request_i,
  input  logic [ADDR_W-1:0] way1_instAddr_i,
  output logic [DATA_W-1:0] way1_inst_o,
  output logic              way1_dataOk_o,
  output logic              mem_request_o,
  output logic [ADDR_W-1:0] mem_instAddr_o,
  input  logic [DATA_W-1:0] mem_inst_i,
  input  logic              mem_dataOk_i,
  output logic [1:0]        grant_o
`ifdef FETCH_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_grant0_o,
  output logic [31:0]       perf_grant1_o,
  output logic [31:0]       perf_drain_o
`endif
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mem_req_q;
  logic [1:0]        grant_q;

  logic [1:0]        arb_req;
  logic              arb_valid;
  logic              arb_pick;
  logic              rr_advance;
  logic              start;
  logic              resp_ok;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .req_i     (arb_req),
    .advance_i (rr_advance),
    .last_i    (owner_q),
    .valid_o   (arb_valid),
    .pick_o    (arb_pick)
  );

  assign resp_ok = (state_q == ST_BUSY) && mem_dataOk_i && !jumpFlag_i;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    arb_req    = 2'b00;
    rr_advance = 1'b0;
    start      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!jumpFlag_i) begin
          arb_req = {way1_request_i, way0_request_i};
        end
        if (arb_valid) begin
          start   = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_dataOk_i) begin
          rr_advance = 1'b1;
          if (jumpFlag_i) begin
            state_d = ST_IDLE;
          end else begin
            // Back-to-back hand-over: only the non-owner may be granted now.
            arb_req = (owner_q == WAY1) ? {1'b0, way0_request_i}
                                        : {way1_request_i, 1'b0};
            if (arb_valid) begin
              start = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else if (jumpFlag_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mem_dataOk_i) begin
          rr_advance = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      owner_d = arb_pick;
      addr_d  = (arb_pick == WAY1) ? way1_instAddr_i : way0_instAddr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= WAY0;
      addr_q    <= '0;
      mem_req_q <= 1'b0;
      grant_q   <= GNT_NONE;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      mem_req_q <= (state_d != ST_IDLE);
      grant_q   <= (state_d != ST_IDLE) ? way_onehot(owner_d) : GNT_NONE;
    end
  end

  assign mem_request_o  = mem_req_q;
  assign mem_instAddr_o = addr_q;
  assign grant_o        = grant_q;

  assign way0_dataOk_o = resp_ok && (owner_q == WAY0);
  assign way1_dataOk_o = resp_ok && (owner_q == WAY1);
  assign way0_inst_o   = way0_dataOk_o ? mem_inst_i : '0;
  assign way1_inst_o   = way1_dataOk_o ? mem_inst_i : '0;

`ifdef FETCH_ARB_PERF_CNT_EN
  logic [31:0] perf_g0_q, perf_g1_q, perf_dr_q;
  logic        drain_evt;

  // A redirect while BUSY either enters DRAIN or suppresses a response.
  assign drain_evt = (state_q == ST_BUSY) && jumpFlag_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_g0_q <= '0;
      perf_g1_q <= '0;
      perf_dr_q <= '0;
    end else begin
      if (start && (arb_pick == WAY0) && !(&perf_g0_q)) perf_g0_q <= perf_g0_q + 32'd1;
      if (start && (arb_pick == WAY1) && !(&perf_g1_q)) perf_g1_q <= perf_g1_q + 32'd1;
      if (drain_evt && !(&perf_dr_q))                   perf_dr_q <= perf_dr_q + 32'd1;
    end
  end

  assign perf_grant0_o = perf_g0_q;
  assign perf_grant1_o = perf_g1_q;
  assign perf_drain_o  = perf_dr_q;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_port_arbiter.md
Name: fetch_port_arbiter

Overview:
- Shares one instruction-memory fetch port between the two fetch ways (way0, way1) of the dual-way core.
- Each way uses a request/dataOk handshake: it holds `request` and `instAddr` until `dataOk`.
- Round-robin grant, one outstanding memory transaction at a time.
- On a redirect (`jumpFlag_i`), stale in-flight responses are drained and discarded.

Parameters:
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction width

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- jumpFlag_i  in  1  redirect; pending/in-flight fetches are stale
- way0_request_i  in  1  way0 fetch request, level, held until way0_dataOk_o
- way0_instAddr_i  in  ADDR_W  way0 fetch address, stable while request high
- way0_inst_o  out  DATA_W  fetched instruction to way0
- way0_dataOk_o  out  1  one-cycle response strobe to way0
- way1_request_i  in  1  as way0
- way1_instAddr_i  in  ADDR_W  as way0
- way1_inst_o  out  DATA_W  as way0
- way1_dataOk_o  out  1  as way0
- mem_request_o  out  1  memory request, held until mem_dataOk_i
- mem_instAddr_o  out  ADDR_W  latched address of granted way
- mem_inst_i  in  DATA_W  memory read data, valid with mem_dataOk_i
- mem_dataOk_i  in  1  memory response strobe
- grant_o  out  2  one-hot current owner (debug), 0 when idle

Behaviour:
- Reset values:
  - State is IDLE.
  - rr pointer favours way0.
  - mem_request_o=0, mem_instAddr_o=0, grant_o=0.
  - Both dataOk_o=0 and both inst_o=0.
  - Applies the same cycle reset is sampled, including mid-transaction. Memory is reset alongside, so no response is expected after reset.
- FSM states: IDLE, BUSY, DRAIN.
- IDLE:
  - If jumpFlag_i, no grant.
  - Else, if any request, pick the winner: the sole requester, or the rr-favoured way when both request.
  - Latch the winner's address into mem_instAddr_o, set owner, go BUSY.
  - mem_request_o rises the next cycle. Latency from request to memory is 1 cycle.
- BUSY:
  - mem_request_o=1; address and owner are stable.
  - When mem_dataOk_i=1 and jumpFlag_i=0:
    - The owner's dataOk_o=1 combinationally, same cycle.
    - The owner's inst_o=mem_inst_i.
    - The rr pointer flips to favour the non-owner.
    - If the non-owner is requesting, grant it directly: stay BUSY, new owner and address next cycle (zero idle cycles).
    - Otherwise go IDLE. The completing way's own request is never re-granted in its dataOk cycle.
  - When mem_dataOk_i=1 and jumpFlag_i=1: suppress dataOk, flip the rr pointer, go IDLE.
  - When mem_dataOk_i=0 and jumpFlag_i=1: go DRAIN.
- DRAIN:
  - mem_request_o stays 1 until mem_dataOk_i.
  - The response is discarded: no way dataOk.
  - Flip the rr pointer, go IDLE.
  - jumpFlag_i during DRAIN has no further effect.
- Outputs:
  - inst_o of the non-owner way is 0.
  - dataOk_o is never asserted to a way whose request_i is low.
  - At most one dataOk_o is high per cycle.
- A request dropped without dataOk (protocol violation) is not required to be handled, except after jumpFlag_i.

Optional Feature:
- Macro FETCH_ARB_PERF_CNT_EN.
- When defined, adds outputs perf_grant0_o[31:0], perf_grant1_o[31:0] and perf_drain_o[31:0]:
  - The grant counters count each transaction start per way.
  - perf_drain_o counts entries to DRAIN plus dataOk suppressions.
  - Counters are saturating, reset to 0.
- When undefined, the ports and counters are absent and the remaining behaviour is identical.

Decomposition:
- Package fetch_arb_pkg holds:
  - the state enum (IDLE/BUSY/DRAIN)
  - WAY0/WAY1 index constants
  - the one-hot grant encodings
- One sub-module, rr_arbiter2:
  - combinational 2-way pick from req[1:0] plus the pointer
  - a registered pointer with an advance input

Test Plan:
- way0 request, addr 0x80000000, memory responds 3 cycles after mem_request_o -> mem_request_o rises 1 cycle after request, mem_instAddr_o=0x80000000, way0_dataOk_o pulses with inst = mem_inst_i, way1 untouched.
- Both ways request in the same cycle after reset, way0 addr 0x100, way1 addr 0x200 -> way0 is served first, way1 is granted in the cycle after way0's dataOk with no IDLE gap, mem_instAddr_o=0x200.
- Both ways request continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
- jumpFlag_i pulsed 1 cycle after way1 is granted, response 4 cycles later -> DRAIN, mem_request_o held until mem_dataOk_i, no way1_dataOk_o, IDLE next cycle, then way0 is favoured.
- jumpFlag_i coincident with mem_dataOk_i -> no dataOk_o to either way, IDLE next cycle.
- reset asserted while BUSY -> next cycle mem_request_o=0, grant_o=0, state IDLE; the first request after reset is way0 if both request.
